// File: rtl/ltc2308_pkg.sv
// ----------------------------------------------------------------------------
// ltc2308_pkg
// Shared definitions for the LTC2308 ADC emulator:
//   - state_e        : emulator FSM states
//   - CFG_RESET      : config word loaded on reset (single-ended CH0, unipolar, awake)
//   - CFG_*          : bit positions inside the 6-bit config word
//                      {S/D, O/S, S1, S0, UNI, SLP}
//   - FRAME_SCK      : SCK periods in one read frame
//   - CFG_BITS       : config bits shifted in at the start of a frame
//   - cfg_channel()  : channel index selected by a config word
// ----------------------------------------------------------------------------
package ltc2308_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StConvert,
      StReady,
      StShift,
      StSleep
   } state_e;

   localparam logic [5:0] CFG_RESET = 6'b100010;

   localparam int unsigned CFG_SD  = 5;
   localparam int unsigned CFG_OS  = 4;
   localparam int unsigned CFG_S1  = 3;
   localparam int unsigned CFG_S0  = 2;
   localparam int unsigned CFG_UNI = 1;
   localparam int unsigned CFG_SLP = 0;

   localparam logic [3:0] FRAME_SCK = 4'd12;
   localparam logic [3:0] CFG_BITS  = 4'd6;

   // Channel index is {S1, S0, O/S}.
   function automatic logic [2:0] cfg_channel(input logic [5:0] cfg);
      return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
   endfunction

endpackage

// File: rtl/ltc2308_emu_if.sv
// ----------------------------------------------------------------------------
// ltc2308_emu_if
// Bundles the serial ADC pins and the sample/status side-band of the emulator.
//   convst, sck, sdi : from the ADC master
//   sdo              : conversion result back to the master
//   sample_req/ch    : request for a new sample value on a channel
//   sample_data      : sample value supplied by the stimulus side
//   cfg_word         : last complete config word
//   busy, frame_done : status
// Modports: slave (the emulator), master (ADC master + stimulus side).
// ----------------------------------------------------------------------------
interface ltc2308_emu_if;

   logic        convst;
   logic        sck;
   logic        sdi;
   logic        sdo;
   logic        sample_req;
   logic [2:0]  sample_ch;
   logic [11:0] sample_data;
   logic [5:0]  cfg_word;
   logic        busy;
   logic        frame_done;

   modport slave (
      input  convst, sck, sdi, sample_data,
      output sdo, sample_req, sample_ch, cfg_word, busy, frame_done
   );

   modport master (
      output convst, sck, sdi, sample_data,
      input  sdo, sample_req, sample_ch, cfg_word, busy, frame_done
   );

endinterface

// File: rtl/ltc2308_emu_sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchroniser for one asynchronous input plus single-cycle rise
// and fall pulses derived from the synchronised level.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_d          : asynchronous input
//   o_q          : synchronised level
//   o_rise       : one-cycle pulse on a synchronised 0->1 transition
//   o_fall       : one-cycle pulse on a synchronised 1->0 transition
// ----------------------------------------------------------------------------
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_q    = r_sync[SYNC_STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/ltc2308_emu.sv
// ----------------------------------------------------------------------------
// ltc2308_emu
// Behavioural emulator of an LTC2308 12-bit ADC serial interface, clocked by
// a fast system clock that oversamples CONVST/SCK/SDI.
//   i_clk  : system clock (>= 4x SCK)
//   i_rst  : asynchronous active-high reset
//   io_bus : ltc2308_emu_if.slave
//            convst/sck/sdi in, sdo out, sample_req/sample_ch out,
//            sample_data in, cfg_word/busy/frame_done out
// A CONVST rise requests a sample, waits CONV_CYCLES, then the result is
// shifted out MSB first on SCK falls while the next config word is shifted in
// on SCK rises.
// ----------------------------------------------------------------------------
module ltc2308_emu
   import ltc2308_pkg::*;
#(
   parameter int unsigned CONV_CYCLES = 64,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic          i_clk,
   input logic          i_rst,
   ltc2308_emu_if.slave io_bus
);

   localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

   // Synchronised inputs and edge pulses
   logic w_convst_q, w_convst_rise, w_convst_fall;
   logic w_sck_q, w_sck_rise, w_sck_fall;
   logic w_sdi_q, w_sdi_rise, w_sdi_fall;
   logic w_start;
   logic w_unused;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic [3:0]      r_rise_cnt;
   logic [3:0]      r_fall_cnt;
   logic [5:0]      r_sr;
   logic [11:0]     r_result;
   logic [5:0]      r_cfg;
   logic            r_sample_req;
   logic [2:0]      r_sample_ch;
   logic            r_busy;
   logic            r_frame_done;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_convst (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (io_bus.convst),
      .o_q    (w_convst_q),
      .o_rise (w_convst_rise),
      .o_fall (w_convst_fall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (io_bus.sck),
      .o_q    (w_sck_q),
      .o_rise (w_sck_rise),
      .o_fall (w_sck_fall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (io_bus.sdi),
      .o_q    (w_sdi_q),
      .o_rise (w_sdi_rise),
      .o_fall (w_sdi_fall)
   );

   // Edges not needed by the protocol; sr[5] falls off the end once cfg is loaded.
   assign w_unused = ^{w_convst_fall, w_sck_q, w_sdi_rise, w_sdi_fall, r_sr[5]};

   // A CONVST rise starts a conversion from IDLE and aborts a read frame.
   assign w_start = w_convst_rise && (r_state inside {StIdle, StReady, StShift});

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_rise_cnt   <= '0;
         r_fall_cnt   <= '0;
         r_sr         <= '0;
         r_result     <= '0;
         r_cfg        <= CFG_RESET;
         r_sample_req <= 1'b0;
         r_sample_ch  <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_sample_req <= 1'b0;
         r_frame_done <= 1'b0;

         // Sample arrives the cycle after the request; bipolar mode flips the
         // MSB to turn offset binary into two's complement.
         if (r_sample_req) begin
            r_result <= io_bus.sample_data ^ {~r_cfg[CFG_UNI], 11'b0};
         end

         if (w_start) begin
            r_state      <= StConvert;
            r_cnt        <= CntW'(CONV_CYCLES - 1);
            r_sample_req <= 1'b1;
            r_sample_ch  <= cfg_channel(r_cfg);
            r_busy       <= 1'b1;
            r_rise_cnt   <= '0;
            r_fall_cnt   <= '0;
            r_sr         <= '0;
         end else begin
            unique case (r_state)
               StIdle: ;

               StConvert: begin
                  if (r_cnt == '0) begin
                     r_state <= StReady;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end

               StReady, StShift: begin
                  if (w_sck_rise) begin
                     r_state <= StShift;
                     if (r_rise_cnt < CFG_BITS) begin
                        r_sr       <= {r_sr[4:0], w_sdi_q};
                        r_rise_cnt <= r_rise_cnt + 4'd1;
                        if (r_rise_cnt == CFG_BITS - 4'd1) begin
                           r_cfg <= {r_sr[4:0], w_sdi_q};
                        end
                     end
                  end else if (w_sck_fall && (r_state == StShift)) begin
                     r_result   <= {r_result[10:0], 1'b0};
                     r_fall_cnt <= r_fall_cnt + 4'd1;
                     if (r_fall_cnt == FRAME_SCK - 4'd1) begin
                        r_frame_done <= 1'b1;
                        r_state      <= r_cfg[CFG_SLP] ? StSleep : StIdle;
                     end
                  end
               end

               StSleep: begin
                  // Wake-up only: this CONVST rise does not convert.
                  if (w_convst_rise) begin
                     r_cfg[CFG_SLP] <= 1'b0;
                     r_state        <= StIdle;
                  end
               end

               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // SDO is a pure decode of flops: MSB of the result while the frame is open.
   assign io_bus.sdo = (((r_state == StReady) && !w_convst_q) || (r_state == StShift))
                       ? r_result[11] : 1'b0;

   assign io_bus.sample_req = r_sample_req;
   assign io_bus.sample_ch  = r_sample_ch;
   assign io_bus.cfg_word   = r_cfg;
   assign io_bus.busy       = r_busy;
   assign io_bus.frame_done = r_frame_done;

endmodule
